// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the pipeline and a tagged request/response bus.
// Loads issue one address request and collect RESP_BEATS response beats, keeping the
// beat that holds the addressed word. Stores issue an address beat, then a data beat.
// Optional build macro: MEM_MISALIGN_CHECK_EN rejects accesses not aligned to their size
// without touching the bus. When it is undefined, misaligned bytes past the word are dropped.
module mem_access_unit #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned RESP_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inValid,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic [BUS_DATA_WIDTH-1:0] inAddr,
  input  logic [BUS_DATA_WIDTH-1:0] inStoreData,
  input  logic [1:0]                inStoreType,
  input  logic [2:0]                inLoadType,
  input  logic [4:0]                inDestRegister,
  input  logic                      inRegWrite,
  input  logic                      inMemOrReg,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      outStall,
  output logic                      outValid,
  output logic [BUS_DATA_WIDTH-1:0] outReadData,
  output logic [BUS_DATA_WIDTH-1:0] outResult,
  output logic [4:0]                outDestRegister,
  output logic                      outRegWrite,
  output logic                      outMemOrReg,
  output logic                      outMisalign
);

  localparam int unsigned BEAT_BITS = $clog2(RESP_BEATS);
  localparam int unsigned SEL_LSB   = 3;
  localparam int unsigned SEL_MSB   = BEAT_BITS + SEL_LSB - 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    WR_ADDR,
    WR_DATA
  } state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] addrQ;
  logic [BUS_DATA_WIDTH-1:0] storeDataQ;
  logic [BUS_DATA_WIDTH-1:0] capWord;
  logic [1:0]                storeTypeQ;
  logic [2:0]                loadTypeQ;
  logic [BEAT_BITS-1:0]      beatCnt;
  logic                      selBeat;
  logic                      lastBeat;
  logic                      unusedRespTag;

  // Request tag: bit 12 marks a read, bits 11:8 carry the fixed unit id.
  function automatic logic [BUS_TAG_WIDTH-1:0] makeTag(input logic isRead);
    logic [BUS_TAG_WIDTH-1:0] t;
    t       = '0;
    t[12]   = isRead;
    t[11:8] = 4'b0011;
    return t;
  endfunction

  // Pick the addressed bytes out of a bus word and sign/zero extend them.
  function automatic logic [BUS_DATA_WIDTH-1:0] extendLoad(
    input logic [BUS_DATA_WIDTH-1:0] word,
    input logic [2:0]                off,
    input logic [2:0]                ltype
  );
    logic [BUS_DATA_WIDTH-1:0] sh;
    logic [BUS_DATA_WIDTH-1:0] r;
    sh = word >> {off, 3'b000};
    case (ltype)
      3'b000:  r = sh;
      3'b001:  r = {{(BUS_DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b010:  r = {{(BUS_DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b011:  r = {{(BUS_DATA_WIDTH-32){sh[31]}}, sh[31:0]};
      3'b100:  r = {{(BUS_DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  r = {{(BUS_DATA_WIDTH-16){1'b0}}, sh[15:0]};
      3'b110:  r = {{(BUS_DATA_WIDTH-32){1'b0}}, sh[31:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Mask store data to its size and move it to its byte lane; bytes past the word fall off.
  function automatic logic [BUS_DATA_WIDTH-1:0] storeBeat(
    input logic [BUS_DATA_WIDTH-1:0] data,
    input logic [2:0]                off,
    input logic [1:0]                stype
  );
    logic [BUS_DATA_WIDTH-1:0] m;
    case (stype)
      2'b00:   m = '1;
      2'b01:   m = {{(BUS_DATA_WIDTH-32){1'b0}}, {32{1'b1}}};
      2'b10:   m = {{(BUS_DATA_WIDTH-16){1'b0}}, {16{1'b1}}};
      default: m = {{(BUS_DATA_WIDTH-8){1'b0}}, {8{1'b1}}};
    endcase
    return (data & m) << {off, 3'b000};
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  // True when the low address bits are not a multiple of the access size.
  function automatic logic isMisaligned(
    input logic       isRead,
    input logic [2:0] ltype,
    input logic [1:0] stype,
    input logic [2:0] off
  );
    logic [2:0] m;
    if (isRead) begin
      case (ltype)
        3'b000:        m = 3'b111;
        3'b010, 3'b101: m = 3'b001;
        3'b011, 3'b110: m = 3'b011;
        default:       m = 3'b000;
      endcase
    end else begin
      case (stype)
        2'b00:   m = 3'b111;
        2'b01:   m = 3'b011;
        2'b10:   m = 3'b001;
        default: m = 3'b000;
      endcase
    end
    return |(off & m);
  endfunction
`else
  assign outMisalign = 1'b0;
`endif

  assign selBeat       = (beatCnt == addrQ[SEL_MSB:SEL_LSB]);
  assign lastBeat      = (beatCnt == BEAT_BITS'(RESP_BEATS - 1));
  assign unusedRespTag = ^bus_resptag;

  // Response beats are acknowledged in the same cycle they arrive, only while collecting.
  assign bus_respack = ~reset & (state == RD_RESP) & bus_respcyc;

  // Hold upstream while busy or while a memory op is being accepted.
  assign outStall = ~reset & ((state != IDLE) | (inValid & (inMemRead | inMemWrite)));

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      addrQ           <= '0;
      storeDataQ      <= '0;
      capWord         <= '0;
      storeTypeQ      <= '0;
      loadTypeQ       <= '0;
      beatCnt         <= '0;
      bus_reqcyc      <= 1'b0;
      bus_req         <= '0;
      bus_reqtag      <= '0;
      outValid        <= 1'b0;
      outReadData     <= '0;
      outResult       <= '0;
      outDestRegister <= '0;
      outRegWrite     <= 1'b0;
      outMemOrReg     <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      outMisalign     <= 1'b0;
`endif
    end else begin
      outValid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      outMisalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (inValid) begin
            addrQ           <= inAddr;
            storeDataQ      <= inStoreData;
            storeTypeQ      <= inStoreType;
            loadTypeQ       <= inLoadType;
            beatCnt         <= '0;
            outResult       <= inAddr;
            outDestRegister <= inDestRegister;
            outMemOrReg     <= inMemOrReg;
            if (inMemRead || inMemWrite) begin
`ifdef MEM_MISALIGN_CHECK_EN
              if (isMisaligned(inMemRead, inLoadType, inStoreType, inAddr[2:0])) begin
                outValid    <= 1'b1;
                outMisalign <= 1'b1;
                outRegWrite <= 1'b0;
                outReadData <= '0;
              end else
`endif
              if (inMemRead) begin
                state       <= RD_REQ;
                bus_reqcyc  <= 1'b1;
                bus_req     <= inAddr;
                bus_reqtag  <= makeTag(1'b1);
                outRegWrite <= inRegWrite;
              end else begin
                state       <= WR_ADDR;
                bus_reqcyc  <= 1'b1;
                bus_req     <= inAddr;
                bus_reqtag  <= makeTag(1'b0);
                outRegWrite <= 1'b0;
              end
            end else begin
              outValid    <= 1'b1;
              outRegWrite <= inRegWrite;
              outReadData <= '0;
            end
          end
        end
        RD_REQ: begin
          if (bus_reqack) begin
            state      <= RD_RESP;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
          end
        end
        RD_RESP: begin
          if (bus_respcyc) begin
            if (selBeat) begin
              capWord <= bus_resp;
            end
            if (lastBeat) begin
              state       <= IDLE;
              beatCnt     <= '0;
              outValid    <= 1'b1;
              outReadData <= extendLoad(selBeat ? bus_resp : capWord, addrQ[2:0], loadTypeQ);
            end else begin
              beatCnt <= beatCnt + BEAT_BITS'(1);
            end
          end
        end
        WR_ADDR: begin
          if (bus_reqack) begin
            state   <= WR_DATA;
            bus_req <= storeBeat(storeDataQ, addrQ[2:0], storeTypeQ);
          end
        end
        WR_DATA: begin
          if (bus_reqack) begin
            state       <= IDLE;
            bus_reqcyc  <= 1'b0;
            bus_req     <= '0;
            bus_reqtag  <= '0;
            outValid    <= 1'b1;
            outRegWrite <= 1'b0;
            outReadData <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, meaning bus/data word width in bits.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, meaning bus tag width.
REQ-003 SHALL have parameter RESP_BEATS, default 8, meaning read-response beats per request (power of 2).
REQ-004 SHALL have one clock and an asynchronous active-high reset, with ports as follows:
- clk  in  1  clock
- reset  in  1  async, active-high
- inValid  in  1  op present
- inMemRead  in  1  load
- inMemWrite  in  1  store
- inAddr  in  BUS_DATA_WIDTH  effective address / ALU result
- inStoreData  in  BUS_DATA_WIDTH  store source
- inStoreType  in  2  00 sd, 01 sw, 10 sh, 11 sb
- inLoadType  in  3  000 ld, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu, 110 lwu
- inDestRegister  in  5  writeback register
- inRegWrite  in  1  register write enable
- inMemOrReg  in  1  writeback select
- bus_reqcyc  out  1  request valid
- bus_reqack  in  1  request accepted
- bus_req  out  BUS_DATA_WIDTH  address or data beat
- bus_reqtag  out  BUS_TAG_WIDTH  request tag
- bus_respcyc  in  1  response beat valid
- bus_resp  in  BUS_DATA_WIDTH  response data
- bus_resptag  in  BUS_TAG_WIDTH  response tag (ignored)
- bus_respack  out  1  response beat accepted
- outStall  out  1  hold upstream
- outValid  out  1  one-cycle completion pulse
- outReadData  out  BUS_DATA_WIDTH  extended load data
- outResult  out  BUS_DATA_WIDTH  latched inAddr
- outDestRegister  out  5  latched inDestRegister
- outRegWrite  out  1  latched inRegWrite, forced 0 for stores
- outMemOrReg  out  1  latched inMemOrReg
- outMisalign  out  1  misaligned access flag

Function
REQ-005 SHALL implement FSM states IDLE, RD_REQ, RD_RESP, WR_ADDR, WR_DATA.
REQ-006 SHALL, in IDLE with inValid and inMemRead, latch all inputs and go to RD_REQ; read SHALL win when inMemRead and inMemWrite are both 1.
REQ-007 SHALL, in RD_REQ, drive bus_reqcyc=1, bus_req=latched address, and bus_reqtag[12]=1 (READ), [11:8]=4'b0011, rest 0; hold these until bus_reqack, then go to RD_RESP.
REQ-008 SHALL, in RD_RESP, assert bus_respack with every bus_respcyc, count beats 0..RESP_BEATS-1, and capture the beat whose index equals address[log2(RESP_BEATS)+2:3].
REQ-009 SHALL, on the last beat, return to IDLE and pulse outValid the next cycle with outReadData extended per REQ-012.
REQ-010 SHALL, for stores, go IDLE->WR_ADDR with tag[12]=0, [11:8]=4'b0011, bus_req=address, then on bus_reqack go to WR_DATA with bus_req=store data shifted by address[2:0]*8 and masked to the store size.
REQ-011 SHALL, on the WR_DATA bus_reqack, return to IDLE and pulse outValid with outRegWrite=0.
REQ-012 SHALL extract load data at byte offset address[2:0]: lb/lh/lw sign-extended, lbu/lhu/lwu zero-extended, ld whole word; inLoadType 3'b111 SHALL yield 0.
REQ-013 SHALL treat inValid with neither read nor write as a pass-through: outValid one cycle later, no stall, no bus activity.
REQ-014 SHALL drive outStall = (state != IDLE) | (IDLE & inValid & (inMemRead | inMemWrite)).
REQ-015 SHALL hold bus_respack=0 and ignore bus_respcyc outside RD_RESP.
REQ-016 SHALL hold bus_reqcyc=0 outside RD_REQ, WR_ADDR and WR_DATA.

Reset
REQ-017 SHALL, on reset, go to IDLE with beat counter 0 and every output 0, effective immediately without waiting for clk.
REQ-018 SHALL, when reset occurs mid-transaction, abandon it with no outValid pulse and no response acknowledgement.

Configuration
REQ-019 SHALL, when MEM_MISALIGN_CHECK_EN is defined, treat an access with address not aligned to its size as follows: no bus request, and outValid with outMisalign=1 and outRegWrite=0 one cycle later.
REQ-020 SHALL, when MEM_MISALIGN_CHECK_EN is undefined, tie outMisalign to 0 and drop bytes that fall beyond the 8-byte word.

Verification
REQ-021 SHALL cover: ld at 0x1010, reqack after 2 cycles, 8 beats of value n*0x11 -> beat 2 captured, outReadData=0x22, single outValid pulse.
REQ-022 SHALL cover: lb at 0x1003 with captured word 0x00000000_80FF0000 -> outReadData=0xFFFFFFFF_FFFFFF80; lbu at the same address -> 0x80.
REQ-023 SHALL cover: sh at 0x2006 of 0xABCD1234 -> address beat 0x2006 with tag 0x1300 minus bit 12, i.e. 0x0300; data beat 0x1234_0000_0000_0000.
REQ-024 SHALL cover: read and write both set -> read path taken, tag 0x1300, no WR_ADDR.
REQ-025 SHALL cover: reset asserted during beat 4 -> outputs 0 at once, IDLE, no outValid; next ld completes normally.
REQ-026 SHALL cover, with MEM_MISALIGN_CHECK_EN: lw at 0x1002 -> bus_reqcyc stays 0, outMisalign=1 for one cycle.
